// File: rtl/dest_dispatch_ctrl_pkg.sv
// Shared constants for the destination dispatch controller.
// State encoding, node width and default payload width.
package dest_dispatch_ctrl_pkg;

    localparam int DDP_NODE_W = 16;
    localparam int DDP_DATA_W = 32;

    typedef enum logic [1:0] {
        DDP_IDLE   = 2'd0,
        DDP_SEND_T = 2'd1,
        DDP_SEND_F = 2'd2
    } ddp_state_e;

endpackage

// File: rtl/ddp_sat_cnt.sv
// 16-bit saturating event counter, built only with DDP_TERM_CNT_EN.
// Ports: clk_i, rst_ni (async low), inc_i, cnt_o.
`ifdef DDP_TERM_CNT_EN
module ddp_sat_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/dest_dispatch_ctrl.sv
// Dispatches a destination result as one (t) or two (t then f) tokens.
// Ports: rslt_* in (valid/ready), tkn_* out (valid/ready), flush_i_ddp,
// busy_o_ddp; term_cnt_o_ddp only with DDP_TERM_CNT_EN.
module dest_dispatch_ctrl
    import dest_dispatch_ctrl_pkg::*;
#(
    parameter int DATA_W = DDP_DATA_W
) (
    input  logic                  clk_i_ddp,
    input  logic                  rst_n_i_ddp,
    input  logic                  flush_i_ddp,
    input  logic                  rslt_valid_i_ddp,
    output logic                  rslt_ready_o_ddp,
    input  logic [DDP_NODE_W-1:0] t_node_i_ddp,
    input  logic [DDP_NODE_W-1:0] f_node_i_ddp,
    input  logic                  t_lr_i_ddp,
    input  logic                  f_lr_i_ddp,
    input  logic                  t_uni_opr_i_ddp,
    input  logic                  f_uni_opr_i_ddp,
    input  logic                  cp_i_ddp,
    input  logic                  terminate_i_ddp,
    input  logic [DATA_W-1:0]     data_i_ddp,
    output logic                  tkn_valid_o_ddp,
    input  logic                  tkn_ready_i_ddp,
    output logic [DDP_NODE_W-1:0] tkn_node_o_ddp,
    output logic                  tkn_lr_o_ddp,
    output logic                  tkn_uni_opr_o_ddp,
    output logic [DATA_W-1:0]     tkn_data_o_ddp,
    output logic                  busy_o_ddp
`ifdef DDP_TERM_CNT_EN
    ,
    output logic [15:0]           term_cnt_o_ddp
`endif
);

    ddp_state_e state_q, state_d;
    logic       cp_q, cp_d;

    // f-side fields kept for the second token of a copy
    logic [DDP_NODE_W-1:0] f_node_q, f_node_d;
    logic                  f_lr_q, f_lr_d;
    logic                  f_uni_q, f_uni_d;

    // registered token outputs; they hold while IDLE
    logic [DDP_NODE_W-1:0] node_q, node_d;
    logic                  lr_q, lr_d;
    logic                  uni_q, uni_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic fire;
    logic load_new;
    logic go_f;
    ddp_state_e acc_state;

    always_comb begin
        rslt_ready_o_ddp = 1'b0;
        unique case (state_q)
            DDP_IDLE:   rslt_ready_o_ddp = 1'b1;
            DDP_SEND_T: rslt_ready_o_ddp = ~cp_q & tkn_ready_i_ddp;
            DDP_SEND_F: rslt_ready_o_ddp = tkn_ready_i_ddp;
            default:    rslt_ready_o_ddp = 1'b0;
        endcase
        // ready is forced low while reset is held
        rslt_ready_o_ddp = rslt_ready_o_ddp & ~flush_i_ddp & rst_n_i_ddp;
    end

    assign fire      = rslt_valid_i_ddp & rslt_ready_o_ddp;
    assign load_new  = fire & ~terminate_i_ddp;
    assign acc_state = load_new ? DDP_SEND_T : DDP_IDLE;
    assign go_f      = (state_q == DDP_SEND_T) & cp_q
                     & tkn_ready_i_ddp & ~flush_i_ddp;

    always_comb begin
        state_d  = state_q;
        cp_d     = cp_q;
        f_node_d = f_node_q;
        f_lr_d   = f_lr_q;
        f_uni_d  = f_uni_q;
        node_d   = node_q;
        lr_d     = lr_q;
        uni_d    = uni_q;
        data_d   = data_q;

        unique case (state_q)
            DDP_IDLE: begin
                if (fire) state_d = acc_state;
            end
            DDP_SEND_T: begin
                if (tkn_ready_i_ddp) begin
                    state_d = cp_q ? DDP_SEND_F : acc_state;
                end
            end
            DDP_SEND_F: begin
                if (tkn_ready_i_ddp) state_d = acc_state;
            end
            default: state_d = DDP_IDLE;
        endcase

        if (load_new) begin
            cp_d     = cp_i_ddp;
            f_node_d = f_node_i_ddp;
            f_lr_d   = f_lr_i_ddp;
            f_uni_d  = f_uni_opr_i_ddp;
            node_d   = t_node_i_ddp;
            lr_d     = t_lr_i_ddp;
            uni_d    = t_uni_opr_i_ddp;
            data_d   = data_i_ddp;
        end else if (go_f) begin
            node_d = f_node_q;
            lr_d   = f_lr_q;
            uni_d  = f_uni_q;
        end

        if (flush_i_ddp) begin
            state_d = DDP_IDLE;
            cp_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i_ddp or negedge rst_n_i_ddp) begin
        if (!rst_n_i_ddp) begin
            state_q  <= DDP_IDLE;
            cp_q     <= 1'b0;
            f_node_q <= '0;
            f_lr_q   <= 1'b0;
            f_uni_q  <= 1'b0;
            node_q   <= '0;
            lr_q     <= 1'b0;
            uni_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cp_q     <= cp_d;
            f_node_q <= f_node_d;
            f_lr_q   <= f_lr_d;
            f_uni_q  <= f_uni_d;
            node_q   <= node_d;
            lr_q     <= lr_d;
            uni_q    <= uni_d;
            data_q   <= data_d;
        end
    end

    assign tkn_valid_o_ddp   = (state_q != DDP_IDLE);
    assign busy_o_ddp        = (state_q != DDP_IDLE);
    assign tkn_node_o_ddp    = node_q;
    assign tkn_lr_o_ddp      = lr_q;
    assign tkn_uni_opr_o_ddp = uni_q;
    assign tkn_data_o_ddp    = data_q;

`ifdef DDP_TERM_CNT_EN
    ddp_sat_cnt u_term_cnt (
        .clk_i  (clk_i_ddp),
        .rst_ni (rst_n_i_ddp),
        .inc_i  (fire & terminate_i_ddp),
        .cnt_o  (term_cnt_o_ddp)
    );
`endif

endmodule

// File: doc/dest_dispatch_ctrl.md
DEST_DISPATCH_CTRL -- requirements
Module: dest_dispatch_ctrl

Interface
REQ-001 Parameter: DATA_W, default 32, width of the token payload carried with each destination.
REQ-002 clk_i_ddp  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n_i_ddp  in  1  reset, asynchronous and active-low.
REQ-004 flush_i_ddp  in  1  synchronous abort: drop the held result, return to IDLE.
REQ-005 rslt_valid_i_ddp  in  1  destination-generator result valid.
REQ-006 rslt_ready_o_ddp  out  1  block accepts the result this cycle.
REQ-007 t_node_i_ddp / f_node_i_ddp  in  16 each  true/false next node.
REQ-008 t_lr_i_ddp / f_lr_i_ddp  in  1 each  true/false next left/right flag.
REQ-009 t_uni_opr_i_ddp / f_uni_opr_i_ddp  in  1 each  true/false next unary-operand flag.
REQ-010 cp_i_ddp  in  1  copy: emit both true and false tokens.
REQ-011 terminate_i_ddp  in  1  token dies; emit nothing.
REQ-012 data_i_ddp  in  DATA_W  payload.
REQ-013 tkn_valid_o_ddp  out  1  outgoing token valid.
REQ-014 tkn_ready_i_ddp  in  1  downstream accepts the token.
REQ-015 tkn_node_o_ddp  out  16;  tkn_lr_o_ddp  out  1;  tkn_uni_opr_o_ddp  out  1;  tkn_data_o_ddp  out  DATA_W  outgoing token fields.
REQ-016 busy_o_ddp  out  1  high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, SEND_T and SEND_F, 2-bit encoded.
REQ-018 Accept (fire) = rslt_valid_i_ddp & rslt_ready_o_ddp.
REQ-019 rslt_ready_o_ddp = ~flush_i_ddp & (IDLE | (SEND_T & ~cp_q & tkn_ready_i_ddp) | (SEND_F & tkn_ready_i_ddp)), giving back-to-back throughput of 1 single token per cycle.
REQ-020 Handling of an accepted result:
- terminate_i_ddp=1: discarded, next state IDLE (terminate beats cp).
- otherwise: all fields registered, next state SEND_T.
REQ-021 SEND_T behaviour:
- outputs: tkn_valid_o_ddp=1 with the t_* fields and data.
- on tkn_ready_i_ddp: go to SEND_F if cp_q, else go to the accept outcome (SEND_T or IDLE).
REQ-022 SEND_F behaviour:
- outputs: tkn_valid_o_ddp=1 with the f_* fields and the same data.
- on tkn_ready_i_ddp: go to the accept outcome (SEND_T or IDLE).
REQ-023 Latency: a token is valid 1 cycle after accept; there is no combinational path from rslt_* to tkn_*.
REQ-024 While tkn_valid_o_ddp=1 and tkn_ready_i_ddp=0, all tkn_* outputs hold stable.
REQ-025 In IDLE: tkn_valid_o_ddp=0 and the tkn field outputs hold their last values.
REQ-026 flush_i_ddp=1 forces the next state to IDLE and blocks accept, regardless of tkn_ready_i_ddp.
- A token handshaking in the same cycle counts as delivered.

Reset
REQ-027 Asynchronous assert of rst_n_i_ddp=0 sets the following immediately, mid-token included; the held result is lost:
- state IDLE, tkn_valid_o_ddp=0, all token fields 0, cp_q=0, busy_o_ddp=0.
- rslt_ready_o_ddp=0.
REQ-028 After deassertion, rslt_ready_o_ddp=1 from the first cycle.

Configuration
REQ-029 With DDP_TERM_CNT_EN defined:
- add output term_cnt_o_ddp [15:0], which increments on every accepted terminate result.
- it saturates at 0xFFFF, resets to 0, and is unaffected by flush.
REQ-030 Without DDP_TERM_CNT_EN: the port and counter are absent; all other behaviour is identical.

Structure
REQ-031 A shared package holds:
- state encoding constants DDP_IDLE=2'd0, DDP_SEND_T=2'd1, DDP_SEND_F=2'd2.
- the node width constant 16.
- the DATA_W default.
REQ-032 Sub-module ddp_sat_cnt (16-bit saturating counter) is instantiated only under DDP_TERM_CNT_EN; everything else is a single flat module.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Single token: accept t_node=0x0010, cp=0, term=0, ready held 1 -> one token, node 0x0010, 1 cycle after accept; then IDLE.
- Copy: accept cp=1, t_node=0x0020, f_node=0x0030, data=0xDEADBEEF, ready=1 -> tokens 0x0020 then 0x0030 on consecutive cycles, both data 0xDEADBEEF; rslt_ready low during SEND_T.
- Terminate: accept term=1, cp=1 -> no token, state stays IDLE, term_cnt 0->1 (when DDP_TERM_CNT_EN).
- Backpressure: tkn_ready=0 for 5 cycles in SEND_F -> f fields stable, valid held 1, rslt_ready=0; releasing ready -> token delivered, back-to-back accept on that cycle.
- Flush/reset: flush in SEND_T with cp=1 -> IDLE next cycle, no f token. rst_n low mid-SEND_F -> valid 0 immediately and fields 0.
- Saturation: preload the counter to 0xFFFE, accept 3 terminates -> counter reads 0xFFFF.
